mem_port_arbiter: RTL

Shares the single memory port between the instruction-fetch stage and the data (MEM) stage of the pipelined OTTER core. The memory behind the port has variable latency and uses an M_REQ/M_ACK handshake. The block picks one requester at a time, holds the memory request stable until it completes, and returns the read data. It drives the stall signals that freeze IF and MEM while their access is pending, and uses starvation and timeout counters to guarantee forward progress.

---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and the data stage.
// Holds the granted request stable until M_ACK or timeout; stalls each requester until its DONE.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16,
  parameter int CNT_W        = 5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IF_REQ,
  input  logic [31:0] IF_ADDR,
  output logic        IF_DONE,
  output logic [31:0] IF_RDATA,
  input  logic        D_REQ,
  input  logic        D_WE,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WDATA,
  input  logic [1:0]  D_SIZE,
  input  logic        D_SIGN,
  output logic        D_DONE,
  output logic [31:0] D_RDATA,
  output logic        M_REQ,
  output logic        M_WE,
  output logic [31:0] M_ADDR,
  output logic [31:0] M_WDATA,
  output logic [1:0]  M_SIZE,
  output logic        M_SIGN,
  input  logic        M_ACK,
  input  logic [31:0] M_RDATA,
  output logic        STALL_IF,
  output logic        STALL_MEM,
  output logic        ERR_TIMEOUT
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_tmo_cnt;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_if_done;
  logic              r_d_done;
  logic [31:0]       r_if_rdata;
  logic [31:0]       r_d_rdata;
  logic              r_m_req;
  logic              r_m_we;
  logic [31:0]       r_m_addr;
  logic [31:0]       r_m_wdata;
  logic [1:0]        r_m_size;
  logic              r_m_sign;
  logic              r_err_timeout;

  logic w_if_elig;
  logic w_d_elig;
  logic w_grant_if;
  logic w_grant_d;

  // A requester whose DONE is high is dropping its request, so it must not be re-granted.
  assign w_if_elig  = IF_REQ & ~r_if_done;
  assign w_d_elig   = D_REQ & ~r_d_done;
  assign w_grant_if = w_if_elig & (~w_d_elig | (r_starve_cnt == STARVE_MAX));
  assign w_grant_d  = w_d_elig & ~w_grant_if;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= IDLE;
      r_tmo_cnt     <= '0;
      r_starve_cnt  <= '0;
      r_if_done     <= 1'b0;
      r_d_done      <= 1'b0;
      r_if_rdata    <= '0;
      r_d_rdata     <= '0;
      r_m_req       <= 1'b0;
      r_m_we        <= 1'b0;
      r_m_addr      <= '0;
      r_m_wdata     <= '0;
      r_m_size      <= '0;
      r_m_sign      <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_if_done <= 1'b0;
      r_d_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_if) begin
            r_state      <= BUSY_IF;
            r_m_req      <= 1'b1;
            r_m_we       <= 1'b0;
            r_m_addr     <= IF_ADDR;
            r_m_wdata    <= '0;
            r_m_size     <= 2'd2;
            r_m_sign     <= 1'b0;
            r_tmo_cnt    <= '0;
            r_starve_cnt <= '0;
          end else if (w_grant_d) begin
            r_state   <= BUSY_D;
            r_m_req   <= 1'b1;
            r_m_we    <= D_WE;
            r_m_addr  <= D_ADDR;
            r_m_wdata <= D_WDATA;
            r_m_size  <= D_SIZE;
            r_m_sign  <= D_SIGN;
            r_tmo_cnt <= '0;
            if (w_if_elig && (r_starve_cnt != STARVE_MAX))
              r_starve_cnt <= r_starve_cnt + CNT_W'(1);
          end
        end
        BUSY_IF, BUSY_D: begin
          // ACK takes priority over a timeout landing on the same edge.
          if (M_ACK) begin
            r_state <= IDLE;
            r_m_req <= 1'b0;
            if (r_state == BUSY_IF) begin
              r_if_done  <= 1'b1;
              r_if_rdata <= M_RDATA;
            end else begin
              r_d_done <= 1'b1;
              if (!r_m_we)
                r_d_rdata <= M_RDATA;
            end
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_state       <= IDLE;
            r_m_req       <= 1'b0;
            r_err_timeout <= 1'b1;
            if (r_state == BUSY_IF) begin
              r_if_done  <= 1'b1;
              r_if_rdata <= '0;
            end else begin
              r_d_done  <= 1'b1;
              r_d_rdata <= '0;
            end
          end else begin
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_m_req <= 1'b0;
        end
      endcase
    end
  end

  assign IF_DONE     = r_if_done;
  assign IF_RDATA    = r_if_rdata;
  assign D_DONE      = r_d_done;
  assign D_RDATA     = r_d_rdata;
  assign M_REQ       = r_m_req;
  assign M_WE        = r_m_we;
  assign M_ADDR      = r_m_addr;
  assign M_WDATA     = r_m_wdata;
  assign M_SIZE      = r_m_size;
  assign M_SIGN      = r_m_sign;
  assign ERR_TIMEOUT = r_err_timeout;
  assign STALL_IF    = IF_REQ & ~r_if_done;
  assign STALL_MEM   = D_REQ & ~r_d_done;

endmodule
